// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the post-commit store buffer.
// Build with STORE_BUFFER_FORWARD_EN defined to forward load data from buffered stores.
package store_buffer_pkg;

  localparam int STORE_BUFFER_DEPTH      = 4;
  localparam int STORE_BUFFER_ADDR_WIDTH = 32;
  localparam int STORE_BUFFER_DATA_WIDTH = 32;
  localparam int STORE_BUFFER_BYTES      = STORE_BUFFER_DATA_WIDTH / 8;
  localparam int STORE_BUFFER_OFFSET     = $clog2(STORE_BUFFER_BYTES);

  typedef struct packed {
    logic [STORE_BUFFER_ADDR_WIDTH-STORE_BUFFER_OFFSET-1:0] wordAddress;
    logic [STORE_BUFFER_DATA_WIDTH-1:0]                     data;
    logic [STORE_BUFFER_BYTES-1:0]                          byteEnable;
  } storeBufferEntry_;

  typedef enum logic {
    SB_IDLE,
    SB_BUSY
  } drainState_;

endpackage

// File: rtl/store_buffer_match.sv
// Load-versus-buffer address compare: finds the youngest overlapping entry,
// walking entries oldest-to-youngest starting from head so wrap-around keeps age order.
module store_buffer_match #(
  parameter int DEPTH       = 4,
  parameter int WORD_WIDTH  = 30,
  parameter int BYTES       = 4,
  parameter int PTR_WIDTH   = $clog2(DEPTH),
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic [PTR_WIDTH-1:0]                head,
  input  logic [COUNT_WIDTH-1:0]              count,
  input  logic [DEPTH-1:0][WORD_WIDTH-1:0]    entryWordAddress,
  input  logic [DEPTH-1:0][BYTES-1:0]         entryByteEnable,
  input  logic [WORD_WIDTH-1:0]               loadWordAddress,
  input  logic [BYTES-1:0]                    loadByteEnable,
  output logic                                anyMatch,
  output logic [PTR_WIDTH-1:0]                youngestIndex,
  output logic                                fullCover
);

  logic [PTR_WIDTH-1:0] slot;

  // Later (younger) matches overwrite earlier ones, so the last hit wins.
  always_comb begin
    anyMatch      = 1'b0;
    youngestIndex = head;
    slot          = head;
    for (int age = 0; age < DEPTH; age++) begin
      slot = head + PTR_WIDTH'(age);
      if ((COUNT_WIDTH'(age) < count) &&
          (entryWordAddress[slot] == loadWordAddress) &&
          (|(entryByteEnable[slot] & loadByteEnable))) begin
        anyMatch      = 1'b1;
        youngestIndex = slot;
      end
    end
  end

  assign fullCover = anyMatch &&
                     ((entryByteEnable[youngestIndex] & loadByteEnable) == loadByteEnable);

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order FIFO drained over a valid/complete handshake,
// with load hazard detection; STORE_BUFFER_FORWARD_EN enables store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH       = STORE_BUFFER_DEPTH,
  parameter  int ADDR_WIDTH  = STORE_BUFFER_ADDR_WIDTH,
  parameter  int DATA_WIDTH  = STORE_BUFFER_DATA_WIDTH,
  localparam int BYTES       = DATA_WIDTH / 8,
  localparam int OFFSET      = $clog2(BYTES),
  localparam int WORD_WIDTH  = ADDR_WIDTH - OFFSET,
  localparam int PTR_WIDTH   = $clog2(DEPTH),
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   storeReqValid,
  input  logic [ADDR_WIDTH-1:0]  storeReqAddress,
  input  logic [DATA_WIDTH-1:0]  storeReqData,
  input  logic [BYTES-1:0]       storeReqByteEnable,
  output logic                   storeReqReady,
  input  logic                   loadCheckValid,
  input  logic [ADDR_WIDTH-1:0]  loadCheckAddress,
  input  logic [BYTES-1:0]       loadCheckByteEnable,
  output logic                   loadHazard,
  output logic                   loadForwardValid,
  output logic [DATA_WIDTH-1:0]  loadForwardData,
  output logic                   memStoreValid,
  output logic [ADDR_WIDTH-1:0]  memStoreAddress,
  output logic [DATA_WIDTH-1:0]  memStoreData,
  output logic [BYTES-1:0]       memStoreByteEnable,
  input  logic                   memStoreComplete,
  output logic                   bufferEmpty,
  output logic [COUNT_WIDTH-1:0] occupancy
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] wordAddress;
    logic [DATA_WIDTH-1:0] data;
    logic [BYTES-1:0]      byteEnable;
  } entry_t;

  entry_t                 entries [DEPTH];
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [COUNT_WIDTH-1:0] count;
  drainState_             state;
  logic                   push;
  logic                   pop;

  assign storeReqReady = (count != COUNT_WIDTH'(DEPTH));
  assign push          = storeReqValid && storeReqReady;
  assign pop           = (state == SB_BUSY) && memStoreComplete;
  assign occupancy     = count;
  assign bufferEmpty   = (count == '0);

  // Payload needs no reset: an entry is only ever read while count covers it.
  always_ff @(posedge clock) begin
    if (push) begin
      entries[tail] <= '{wordAddress: storeReqAddress[ADDR_WIDTH-1:OFFSET],
                         data:        storeReqData,
                         byteEnable:  storeReqByteEnable};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_WIDTH'(1);
      if (pop)  head <= head + PTR_WIDTH'(1);
      count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= SB_IDLE;
      memStoreValid      <= 1'b0;
      memStoreAddress    <= '0;
      memStoreData       <= '0;
      memStoreByteEnable <= '0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (count != '0) begin
            memStoreValid      <= 1'b1;
            memStoreAddress    <= ADDR_WIDTH'(entries[head].wordAddress) << OFFSET;
            memStoreData       <= entries[head].data;
            memStoreByteEnable <= entries[head].byteEnable;
            state              <= SB_BUSY;
          end
        end
        SB_BUSY: begin
          if (memStoreComplete) begin
            memStoreValid <= 1'b0;
            state         <= SB_IDLE;
          end
        end
        default: state <= SB_IDLE;
      endcase
    end
  end

  logic [DEPTH-1:0][WORD_WIDTH-1:0] entryWordAddress;
  logic [DEPTH-1:0][BYTES-1:0]      entryByteEnable;
  logic                             anyMatch;
  logic [PTR_WIDTH-1:0]             youngestIndex;
  logic                             fullCover;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryWordAddress[i] = entries[i].wordAddress;
      entryByteEnable[i]  = entries[i].byteEnable;
    end
  end

  store_buffer_match #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (WORD_WIDTH),
    .BYTES      (BYTES),
    .PTR_WIDTH  (PTR_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) match (
    .head            (head),
    .count           (count),
    .entryWordAddress(entryWordAddress),
    .entryByteEnable (entryByteEnable),
    .loadWordAddress (loadCheckAddress[ADDR_WIDTH-1:OFFSET]),
    .loadByteEnable  (loadCheckByteEnable),
    .anyMatch        (anyMatch),
    .youngestIndex   (youngestIndex),
    .fullCover       (fullCover)
  );

  logic unusedAddressBits;
  assign unusedAddressBits = &{1'b0, storeReqAddress, loadCheckAddress};

`ifdef STORE_BUFFER_FORWARD_EN
  logic [DATA_WIDTH-1:0] laneMask;

  always_comb begin
    for (int b = 0; b < BYTES; b++) begin
      laneMask[8*b +: 8] = {8{loadCheckByteEnable[b]}};
    end
  end

  // Only a youngest match that covers every requested lane may forward.
  assign loadHazard       = loadCheckValid && anyMatch && !fullCover;
  assign loadForwardValid = loadCheckValid && anyMatch && fullCover;
  assign loadForwardData  = loadForwardValid ? (entries[youngestIndex].data & laneMask) : '0;
`else
  assign loadHazard       = loadCheckValid && anyMatch;
  assign loadForwardValid = 1'b0;
  assign loadForwardData  = '0;

  logic unusedMatch;
  assign unusedMatch = &{1'b0, youngestIndex, fullCover};
`endif

endmodule
